// File: rtl/vga_window_scaler.sv
// VGA-style timing generator that integer-scales a BRAM framebuffer into a window
// of the active area, with every output delayed to line up with the returned pixel.
module vga_window_scaler #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          SRC_W      = 256,
    parameter int          SRC_H      = 192,
    parameter int          SCALE      = 2,
    parameter int          WIN_X0     = 64,
    parameter int          WIN_Y0     = 48,
    parameter int          RD_LAT     = 2,
    parameter logic [17:0] BORDER_RGB = 18'h0,
    localparam int         ADDR_W     = $clog2(SRC_W * SRC_H)
) (
    input  logic              pixel_clk,
    input  logic              reset,
    output logic              hs,
    output logic              vs,
    output logic              active_nblank,
    output logic              sync,
    output logic [9:0]        drawX,
    output logic [9:0]        drawY,
    output logic              frame_start,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_rd_en,
    input  logic [17:0]       bram_rdata,
    output logic [5:0]        red,
    output logic [5:0]        green,
    output logic [5:0]        blue
);

    localparam int L    = RD_LAT + 2;
    localparam int HT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int AW1  = ADDR_W + 1;
    localparam int PH_W = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [9:0] HT_M1 = 10'(HT - 1);
    localparam logic [9:0] VT_M1 = 10'(VT - 1);
    localparam logic [9:0] HA    = 10'(H_ACTIVE);
    localparam logic [9:0] VA    = 10'(V_ACTIVE);
    localparam logic [9:0] HS0   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS1   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS0   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS1   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] WX0   = 10'(WIN_X0);
    localparam logic [9:0] WX1   = 10'(WIN_X0 + SRC_W * SCALE);
    localparam logic [9:0] WY0   = 10'(WIN_Y0);
    localparam logic [9:0] WY1   = 10'(WIN_Y0 + SRC_H * SCALE);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SCALE - 1);

    if ((WIN_X0 + SRC_W * SCALE > H_ACTIVE) || (WIN_Y0 + SRC_H * SCALE > V_ACTIVE) ||
        (SCALE < 1) || (RD_LAT < 1)) begin : g_bad_geometry
        $error("vga_window_scaler: window does not fit the active area or bad SCALE/RD_LAT");
    end

    logic [9:0]      hc, vc, hc_next, vc_next;
    logic            hc_last;
    logic            x_on, y_on, in_win;
    logic [AW1-1:0]  src_x, row_base, addr_full;
    logic [PH_W-1:0] x_phase, y_phase;

    assign hc_last   = (hc == HT_M1);
    assign hc_next   = hc_last ? 10'd0 : hc + 10'd1;
    assign vc_next   = hc_last ? ((vc == VT_M1) ? 10'd0 : vc + 10'd1) : vc;
    assign in_win    = x_on && y_on;
    assign addr_full = row_base + src_x;

    // x_on / y_on are window flags kept aligned with hc / vc by looking one step ahead.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            hc       <= '0;
            vc       <= '0;
            x_on     <= (WX0 == 10'd0);
            y_on     <= (WY0 == 10'd0);
            src_x    <= '0;
            x_phase  <= '0;
            row_base <= '0;
            y_phase  <= '0;
        end else begin
            hc <= hc_next;
            vc <= vc_next;

            if (hc_next == WX0)      x_on <= 1'b1;
            else if (hc_next == WX1) x_on <= 1'b0;

            if (hc_next == WX0) begin
                src_x   <= '0;
                x_phase <= '0;
            end else if (x_on) begin
                if (x_phase == PH_LAST) begin
                    x_phase <= '0;
                    src_x   <= src_x + AW1'(1);
                end else begin
                    x_phase <= x_phase + PH_W'(1);
                end
            end

            if (hc_last) begin
                if (vc_next == WY0)      y_on <= 1'b1;
                else if (vc_next == WY1) y_on <= 1'b0;

                // Row base advances by SRC_W every SCALE window lines; frame top restarts it.
                if (vc_next == 10'd0) begin
                    row_base <= '0;
                    y_phase  <= '0;
                end else if (y_on) begin
                    if (y_phase == PH_LAST) begin
                        y_phase  <= '0;
                        row_base <= row_base + AW1'(SRC_W);
                    end else begin
                        y_phase <= y_phase + PH_W'(1);
                    end
                end
            end
        end
    end

    logic       hs_raw, vs_raw, act_raw, fs_raw;
    logic [L-1:0] hs_d, vs_d, act_d, win_d, fs_d;
    logic [9:0] dx_d [L];
    logic [9:0] dy_d [L];
    logic [17:0] rgb_q;

    assign hs_raw  = !((hc >= HS0) && (hc < HS1));
    assign vs_raw  = !((vc >= VS0) && (vc < VS1));
    assign act_raw = (hc < HA) && (vc < VA);
    assign fs_raw  = (hc == 10'd0) && (vc == 10'd0);

    // Stage 0 of the delay line is the cycle the address is presented; data for
    // that pixel is on bram_rdata while its flags sit in stage L-2.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            bram_addr  <= '0;
            bram_rd_en <= 1'b0;
            hs_d       <= '1;
            vs_d       <= '1;
            act_d      <= '0;
            win_d      <= '0;
            fs_d       <= '0;
            rgb_q      <= '0;
            for (int k = 0; k < L; k++) begin
                dx_d[k] <= '0;
                dy_d[k] <= '0;
            end
        end else begin
            bram_rd_en <= in_win;
            if (in_win) bram_addr <= addr_full[ADDR_W-1:0];
            hs_d  <= {hs_d[L-2:0], hs_raw};
            vs_d  <= {vs_d[L-2:0], vs_raw};
            act_d <= {act_d[L-2:0], act_raw};
            win_d <= {win_d[L-2:0], in_win};
            fs_d  <= {fs_d[L-2:0], fs_raw};
            dx_d[0] <= hc;
            dy_d[0] <= vc;
            for (int k = 1; k < L; k++) begin
                dx_d[k] <= dx_d[k-1];
                dy_d[k] <= dy_d[k-1];
            end
            if (!act_d[L-2])     rgb_q <= '0;
            else if (win_d[L-2]) rgb_q <= bram_rdata;
            else                 rgb_q <= BORDER_RGB;
        end
    end

    assign hs            = hs_d[L-1];
    assign vs            = vs_d[L-1];
    assign active_nblank = act_d[L-1];
    assign frame_start   = fs_d[L-1];
    assign drawX         = dx_d[L-1];
    assign drawY         = dy_d[L-1];
    assign sync          = 1'b0;
    assign {red, green, blue} = rgb_q;

endmodule

// File: tb/tb_vga_window_scaler.sv
// Bench for vga_window_scaler: two small-timing instances (scaled window and 1:1 window)
// compared every cycle against a pixel-position model built from div/mod arithmetic.
module tb_vga_window_scaler;

    localparam int HA = 40, HF = 4, HSW = 6, HB = 6;
    localparam int VA = 30, VF = 2, VSW = 2, VB = 3;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam int SW = 8, SH = 6;
    localparam logic [17:0] BORDER_A = 18'h2A5A5;
    localparam logic [17:0] BORDER_B = 18'h15A5A;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       hs_a, vs_a, act_a, sync_a, fs_a, en_a;
    logic [9:0] dx_a, dy_a;
    logic [5:0] addr_a, r_a, g_a, b_a;
    logic [17:0] rdata_a;
    logic       hs_b, vs_b, act_b, sync_b, fs_b, en_b;
    logic [9:0] dx_b, dy_b;
    logic [5:0] addr_b, r_b, g_b, b_b;
    logic [17:0] rdata_b;

    vga_window_scaler #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SRC_W(SW), .SRC_H(SH), .SCALE(2), .WIN_X0(5), .WIN_Y0(4),
        .RD_LAT(2), .BORDER_RGB(BORDER_A)
    ) dut_a (
        .pixel_clk(clk), .reset(reset), .hs(hs_a), .vs(vs_a), .active_nblank(act_a),
        .sync(sync_a), .drawX(dx_a), .drawY(dy_a), .frame_start(fs_a),
        .bram_addr(addr_a), .bram_rd_en(en_a), .bram_rdata(rdata_a),
        .red(r_a), .green(g_a), .blue(b_a)
    );

    vga_window_scaler #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SRC_W(SW), .SRC_H(SH), .SCALE(1), .WIN_X0(0), .WIN_Y0(0),
        .RD_LAT(1), .BORDER_RGB(BORDER_B)
    ) dut_b (
        .pixel_clk(clk), .reset(reset), .hs(hs_b), .vs(vs_b), .active_nblank(act_b),
        .sync(sync_b), .drawX(dx_b), .drawY(dy_b), .frame_start(fs_b),
        .bram_addr(addr_b), .bram_rd_en(en_b), .bram_rdata(rdata_b),
        .red(r_b), .green(g_b), .blue(b_b)
    );

    // Framebuffer models: A has two cycles of read latency, B has one.
    logic [17:0] mem_a [64];
    logic [17:0] mem_b [64];
    logic [17:0] qa0, qa1, qb0;
    always @(posedge clk) begin
        qa0 <= mem_a[addr_a];
        qa1 <= qa0;
        qb0 <= mem_b[addr_b];
    end
    assign rdata_a = qa1;
    assign rdata_b = qb0;

    int tests = 0;
    int fails = 0;
    int n = 0;
    int cyc = 0;
    int last_fs = -1;
    int exp_addr [2];

    task automatic check(input string tag, input int id, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d n=%0d observed=%0h expected=%0h", tag, id, n, obs, exp);
        end
    endtask

    function automatic bit in_window(input int id, input int x, input int y);
        int s, wx, wy;
        s  = (id == 0) ? 2 : 1;
        wx = (id == 0) ? 5 : 0;
        wy = (id == 0) ? 4 : 0;
        return (x >= wx) && (x < wx + SW * s) && (y >= wy) && (y < wy + SH * s);
    endfunction

    function automatic int src_addr(input int id, input int x, input int y);
        int s, wx, wy;
        s  = (id == 0) ? 2 : 1;
        wx = (id == 0) ? 5 : 0;
        wy = (id == 0) ? 4 : 0;
        return ((y - wy) / s) * SW + (x - wx) / s;
    endfunction

    task automatic check_dut(input int id);
        logic ohs, ovs, oact, ofs, oen, ohs_e, ovs_e, oact_e, ofs_e, en_e;
        logic [9:0] ox, oy;
        logic [17:0] orgb, rgb_e, border;
        logic [5:0] oaddr, osync;
        int lat, x, y, p, q, ex, ey;
        if (id == 0) begin
            {ohs, ovs, oact, ofs, oen} = {hs_a, vs_a, act_a, fs_a, en_a};
            {ox, oy, oaddr, orgb} = {dx_a, dy_a, addr_a, r_a, g_a, b_a};
            osync = {5'd0, sync_a};
            lat = 2; border = BORDER_A;
        end else begin
            {ohs, ovs, oact, ofs, oen} = {hs_b, vs_b, act_b, fs_b, en_b};
            {ox, oy, oaddr, orgb} = {dx_b, dy_b, addr_b, r_b, g_b, b_b};
            osync = {5'd0, sync_b};
            lat = 1; border = BORDER_B;
        end

        if (n < lat + 2) begin
            {ohs_e, ovs_e, oact_e, ofs_e} = 4'b1100;
            ex = 0; ey = 0; rgb_e = '0;
        end else begin
            p = n - (lat + 2);
            x = p % HT;
            y = (p / HT) % VT;
            ohs_e  = !(x >= HA + HF && x < HA + HF + HSW);
            ovs_e  = !(y >= VA + VF && y < VA + VF + VSW);
            oact_e = (x < HA) && (y < VA);
            ofs_e  = (x == 0) && (y == 0);
            ex = x; ey = y;
            if (!oact_e)                rgb_e = '0;
            else if (in_window(id, x, y)) rgb_e = (id == 0) ? mem_a[src_addr(id, x, y)]
                                                            : mem_b[src_addr(id, x, y)];
            else                        rgb_e = border;
        end

        if (n == 0) begin
            en_e = 1'b0;
            exp_addr[id] = 0;
        end else begin
            q = n - 1;
            x = q % HT;
            y = (q / HT) % VT;
            en_e = in_window(id, x, y);
            if (en_e) exp_addr[id] = src_addr(id, x, y);
        end

        check("hs", id, 32'(ohs), 32'(ohs_e));
        check("vs", id, 32'(ovs), 32'(ovs_e));
        check("active", id, 32'(oact), 32'(oact_e));
        check("frame_start", id, 32'(ofs), 32'(ofs_e));
        check("drawX", id, 32'(ox), 32'(ex));
        check("drawY", id, 32'(oy), 32'(ey));
        check("rgb", id, 32'(orgb), 32'(rgb_e));
        check("rd_en", id, 32'(oen), 32'(en_e));
        check("addr", id, 32'(oaddr), 32'(exp_addr[id]));
        check("sync", id, 32'(osync), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            n = 0;
            last_fs = -1;
        end else begin
            n++;
        end
        check_dut(0);
        check_dut(1);
        if (fs_a === 1'b1) begin
            if (last_fs >= 0) check("frame_period", 0, 32'(cyc - last_fs), 32'(FRAME));
            last_fs = cyc;
        end
    endtask

    initial begin
        int cut;
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 18'($urandom);
            mem_b[i] = 18'($urandom);
        end
        exp_addr[0] = 0;
        exp_addr[1] = 0;

        reset = 1'b1;
        repeat (5) step();
        reset = 1'b0;
        repeat (2 * FRAME + 100) step();

        cut = $urandom_range(300, 1800);
        repeat (cut) step();
        reset = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        reset = 1'b0;
        repeat (2 * FRAME + 50) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_window_scaler.md
Name: vga_window_scaler

Overview:
- Parametrised successor to the fixed 640x480 VGA timing generator.
- Generates configurable sync/blank timing and fetches a SRC_W x SRC_H framebuffer (NDS 256x192 by default) from BRAM.
- Integer-scales the framebuffer by SCALE and places it at (WIN_X0, WIN_Y0) inside the active area; active pixels outside the window show a border colour.
- Sits between the framebuffer BRAM read port and the HDMI encoder; all outputs are pipeline-aligned.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, active lines
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SRC_W, 256, source framebuffer width
SRC_H, 192, source framebuffer height
SCALE, 2, integer scale factor (>=1)
WIN_X0, 64, window left edge in active pixels
WIN_Y0, 48, window top edge in active lines
RD_LAT, 2, BRAM read latency in cycles (>=1)
BORDER_RGB, 18'h0, {r,g,b} colour outside window

Ports:
pixel_clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
hs  out  1  horizontal sync, active low
vs  out  1  vertical sync, active low
active_nblank  out  1  high during active video
sync  out  1  composite sync, tied 0
drawX  out  10  horizontal coordinate, aligned with rgb
drawY  out  10  vertical coordinate, aligned with rgb
frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)
bram_addr  out  clog2(SRC_W*SRC_H)  framebuffer read address
bram_rd_en  out  1  read enable
bram_rdata  in  18  {r,g,b} pixel returned by BRAM
red, green, blue  out  6 each  pixel colour

Behaviour:
- Counters: hc runs 0..HT-1, where HT = sum of the H_* parameters (800). vc increments when hc wraps and runs 0..VT-1, where VT = sum of the V_* parameters (525).
- Sync: hs is low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vs is low for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). Both are registered.
- Pipeline: counter value at cycle t produces bram_addr/bram_rd_en at t+1, data at t+1+RD_LAT, and rgb at t+2+RD_LAT. hs, vs, active_nblank, drawX, drawY and frame_start go through a delay line of L = RD_LAT+2, so every output describes the same pixel.
- Window: in_win = hc in [WIN_X0, WIN_X0+SRC_W*SCALE) and vc in [WIN_Y0, WIN_Y0+SRC_H*SCALE).
- Address generation uses phase counters, no divider:
  - src_x increments every SCALE pixels inside the window and resets at the window's left edge.
  - src_y increments every SCALE lines and resets at the frame top.
  - bram_addr = src_y*SRC_W + src_x, computed without truncation; the multiply may be a running row base incremented by SRC_W.
- bram_rd_en = 1 only while in_win. Outside the window bram_addr holds its last value.
- Colour selection:
  - blanking: rgb = 0
  - active and in_win: rgb = bram_rdata
  - active and not in_win: rgb = BORDER_RGB
- Each source pixel appears SCALE times horizontally, and each source row is re-read for SCALE consecutive lines (no line buffer).
- Reset: hc=vc=0; all pipeline stages cleared; hs=1, vs=1, active_nblank=0, rgb=0, bram_rd_en=0, bram_addr=0, frame_start=0, drawX=drawY=0. Reset mid-frame restarts at (0,0) on the next cycle. Outputs stay at reset values until the pipeline refills (L cycles).
- Boundaries:
  - The last window address, SRC_W*SRC_H-1, occurs on the last window line; src_y never exceeds SRC_H-1.
  - The window must fit inside the active area; this is an elaboration-time check and fails elaboration if violated.
  - SCALE=1 gives one address per pixel.

Test Plan:
- Reset held 5 cycles, then released -> outputs hold reset values; first hs low at output cycle 656+L; frame_start pulses every 420000 cycles.
- Line timing -> hs low exactly 96 cycles per 800; vs low exactly 2 lines (1600 cycles) starting at line 490; active_nblank high for 640x480 per frame.
- Address sequence, default params -> line 48: addrs 0,0,1,1,...,255,255 starting at hc=64; line 49 repeats 0..255; line 50 starts 256; line 431 ends 49151; no rd_en outside window.
- BRAM model with latency 2 returning data = addr -> rgb at drawX=64,drawY=48 is 0; at drawX=66 it is 1; at drawX=63 and drawX=576 it is BORDER_RGB; in blanking it is 0.
- SCALE=1, RD_LAT=1, WIN_X0=0, WIN_Y0=0 -> addr equals drawY*256+drawX within the window; output alignment is L=3.
- Reset asserted at vc=200, hc=300 -> next cycle counters at 0; no stale rd_en; first frame_start L cycles after release.
